// File: rtl/lstm_cell_bp.sv
// LSTM cell backward pass: one timestep's gate deltas, dstate and dc from saved forward values.
// A single shared fixed-point multiplier is sequenced over 16 steps.
module lstm_cell_bp #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_i,
   input  logic [WIDTH-1:0] i_f,
   input  logic [WIDTH-1:0] i_o,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_c_prev,
   input  logic [WIDTH-1:0] i_dh,
   input  logic [WIDTH-1:0] i_dc_next,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_da,
   output logic [WIDTH-1:0] o_di,
   output logic [WIDTH-1:0] o_df,
   output logic [WIDTH-1:0] o_do,
   output logic [WIDTH-1:0] o_dstate,
   output logic [WIDTH-1:0] o_dc
);

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << FRAC;
   localparam logic [WIDTH:0]   T_HALF = (WIDTH+1)'(1) << (FRAC-1);
   localparam logic [WIDTH:0]   T_KNEE = (WIDTH+1)'(5) << (FRAC-1);
   localparam logic [WIDTH:0]   T_OFS  = (WIDTH+1)'(3) << (FRAC-3);
   localparam logic [WIDTH:0]   T_ONE  = (WIDTH+1)'(1) << FRAC;

   // Odd piecewise-linear tanh: x below 0.5, 0.375+x/4 up to 2.5, then 1.0.
   function automatic logic [WIDTH-1:0] tanh_pl(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] mag;
      logic [WIDTH:0] y;
      mag = x[WIDTH-1] ? ({1'b0, ~x} + (WIDTH+1)'(1)) : {1'b0, x};
      if (mag < T_HALF)      y = mag;
      else if (mag < T_KNEE) y = T_OFS + (mag >> 2);
      else                   y = T_ONE;
      return x[WIDTH-1] ? (WIDTH'(0) - y[WIDTH-1:0]) : y[WIDTH-1:0];
   endfunction

   state_t           state_q, state_d;
   logic [4:0]       step_q, step_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] a_q, a_d, i_q, i_d, f_q, f_d, o_q, o_d;
   logic [WIDTH-1:0] t_q, t_d, cp_q, cp_d, dh_q, dh_d, dcn_q, dcn_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, ds_q, ds_d;
   logic [WIDTH-1:0] d_a_q, d_a_d, d_i_q, d_i_d, d_f_q, d_f_d, d_o_q, d_o_d;
   logic [WIDTH-1:0] da_out_q, da_out_d, di_out_q, di_out_d, df_out_q, df_out_d;
   logic [WIDTH-1:0] do_out_q, do_out_d, ds_out_q, ds_out_d, dc_out_q, dc_out_d;

   logic signed [WIDTH-1:0]   mul_a, mul_b;
   logic signed [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]          mul_res;

   // x_q / y_q are scratch slots reused by each gate's pair of partial products.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (step_q)
         5'd1:    begin mul_a = t_q;  mul_b = t_q;        end
         5'd2:    begin mul_a = dh_q; mul_b = o_q;        end
         5'd3:    begin mul_a = y_q;  mul_b = ONE - x_q;  end
         5'd4:    begin mul_a = dh_q; mul_b = t_q;        end
         5'd5:    begin mul_a = o_q;  mul_b = ONE - o_q;  end
         5'd6:    begin mul_a = x_q;  mul_b = y_q;        end
         5'd7:    begin mul_a = a_q;  mul_b = a_q;        end
         5'd8:    begin mul_a = ds_q; mul_b = i_q;        end
         5'd9:    begin mul_a = y_q;  mul_b = ONE - x_q;  end
         5'd10:   begin mul_a = i_q;  mul_b = ONE - i_q;  end
         5'd11:   begin mul_a = ds_q; mul_b = a_q;        end
         5'd12:   begin mul_a = y_q;  mul_b = x_q;        end
         5'd13:   begin mul_a = f_q;  mul_b = ONE - f_q;  end
         5'd14:   begin mul_a = ds_q; mul_b = cp_q;       end
         5'd15:   begin mul_a = y_q;  mul_b = x_q;        end
         5'd16:   begin mul_a = ds_q; mul_b = f_q;        end
         default: ;
      endcase
      prod    = mul_a * mul_b;
      mul_res = WIDTH'(prod >>> FRAC);
   end

   always_comb begin
      state_d  = state_q;   step_d   = step_q;   armed_d  = 1'b1;
      a_d      = a_q;       i_d      = i_q;      f_d      = f_q;      o_d    = o_q;
      t_d      = t_q;       cp_d     = cp_q;     dh_d     = dh_q;     dcn_d  = dcn_q;
      x_d      = x_q;       y_d      = y_q;      ds_d     = ds_q;
      d_a_d    = d_a_q;     d_i_d    = d_i_q;    d_f_d    = d_f_q;    d_o_d  = d_o_q;
      da_out_d = da_out_q;  di_out_d = di_out_q; df_out_d = df_out_q;
      do_out_d = do_out_q;  ds_out_d = ds_out_q; dc_out_d = dc_out_q;
      case (state_q)
         ST_IDLE: begin
            // armed_q blocks a start that coincides with the reset-release edge.
            if (i_start && armed_q) begin
               state_d = ST_MUL;
               step_d  = 5'd1;
               a_d  = i_a;      i_d  = i_i;  f_d   = i_f;  o_d = i_o;
               cp_d = i_c_prev; dh_d = i_dh; dcn_d = i_dc_next;
               t_d  = tanh_pl(i_c);
            end
         end
         ST_MUL: begin
            case (step_q)
               5'd1, 5'd7, 5'd10, 5'd13: x_d = mul_res;
               5'd2, 5'd5, 5'd8, 5'd11, 5'd14: y_d = mul_res;
               5'd3:    ds_d  = mul_res;
               5'd4:    begin ds_d = ds_q + dcn_q; x_d = mul_res; end
               5'd6:    d_o_d = mul_res;
               5'd9:    d_a_d = mul_res;
               5'd12:   d_i_d = mul_res;
               5'd15:   d_f_d = mul_res;
               default: ;
            endcase
            if (step_q == 5'd16) begin
               // Outputs load on entry to DONE so they are valid with o_done.
               state_d  = ST_DONE;
               step_d   = 5'd0;
               da_out_d = d_a_q;  di_out_d = d_i_q;  df_out_d = d_f_q;
               do_out_d = d_o_q;  ds_out_d = ds_q;   dc_out_d = mul_res;
            end else begin
               step_d = step_q + 5'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;  step_q   <= '0;  armed_q  <= 1'b0;
         a_q      <= '0;  i_q      <= '0;  f_q      <= '0;  o_q    <= '0;
         t_q      <= '0;  cp_q     <= '0;  dh_q     <= '0;  dcn_q  <= '0;
         x_q      <= '0;  y_q      <= '0;  ds_q     <= '0;
         d_a_q    <= '0;  d_i_q    <= '0;  d_f_q    <= '0;  d_o_q  <= '0;
         da_out_q <= '0;  di_out_q <= '0;  df_out_q <= '0;
         do_out_q <= '0;  ds_out_q <= '0;  dc_out_q <= '0;
      end else begin
         state_q  <= state_d;   step_q   <= step_d;   armed_q  <= armed_d;
         a_q      <= a_d;       i_q      <= i_d;      f_q      <= f_d;      o_q    <= o_d;
         t_q      <= t_d;       cp_q     <= cp_d;     dh_q     <= dh_d;     dcn_q  <= dcn_d;
         x_q      <= x_d;       y_q      <= y_d;      ds_q     <= ds_d;
         d_a_q    <= d_a_d;     d_i_q    <= d_i_d;    d_f_q    <= d_f_d;    d_o_q  <= d_o_d;
         da_out_q <= da_out_d;  di_out_q <= di_out_d; df_out_q <= df_out_d;
         do_out_q <= do_out_d;  ds_out_q <= ds_out_d; dc_out_q <= dc_out_d;
      end
   end

   assign o_busy   = (state_q != ST_IDLE);
   assign o_done   = (state_q == ST_DONE);
   assign o_da     = da_out_q;
   assign o_di     = di_out_q;
   assign o_df     = df_out_q;
   assign o_do     = do_out_q;
   assign o_dstate = ds_out_q;
   assign o_dc     = dc_out_q;

endmodule

// File: tb/tb_lstm_cell_bp.sv
// Self-checking bench for lstm_cell_bp: directed scenarios plus random transactions
// scored through an expected-result queue.
module tb_lstm_cell_bp;
   localparam int WIDTH = 32;
   localparam int RW    = 6 * WIDTH;
   localparam logic [WIDTH-1:0] ONE  = 32'h01000000;
   localparam logic [WIDTH-1:0] HALF = 32'h00800000;
   localparam logic [RW-1:0] EXP_T1 = {32'h00400000, 32'h0, 32'h0, 32'h0, 32'h00800000, 32'h00400000};
   localparam logic [RW-1:0] EXP_T2 = {32'h00800000, 32'h0, 32'h0, 32'h0, 32'h01000000, 32'h00800000};
   localparam logic [RW-1:0] EXP_T3 = {32'hFFC00000, 32'h0, 32'h0, 32'h0, 32'hFF800000, 32'hFFC00000};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_start = 1'b0;
   logic [WIDTH-1:0] i_a = '0, i_i = '0, i_f = '0, i_o = '0;
   logic [WIDTH-1:0] i_c = '0, i_c_prev = '0, i_dh = '0, i_dc_next = '0;
   logic o_busy, o_done;
   logic [WIDTH-1:0] o_da, o_di, o_df, o_do, o_dstate, o_dc;
   logic [RW-1:0] res;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp_v;
   int total = 0;
   int bad = 0;
   int lat;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   lstm_cell_bp #(.WIDTH(32), .FRAC(24)) dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
      .i_c(i_c), .i_c_prev(i_c_prev), .i_dh(i_dh), .i_dc_next(i_dc_next),
      .o_busy(o_busy), .o_done(o_done),
      .o_da(o_da), .o_di(o_di), .o_df(o_df), .o_do(o_do),
      .o_dstate(o_dstate), .o_dc(o_dc)
   );

   assign res = {o_da, o_di, o_df, o_do, o_dstate, o_dc};

   // reference fixed-point arithmetic
   function automatic logic [WIDTH-1:0] fm(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic signed [2*WIDTH-1:0] p;
      p = $signed(x) * $signed(y);
      p = p >>> 24;
      return p[WIDTH-1:0];
   endfunction

   function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, i, f, o, t, cp, dh, dcn);
      logic [WIDTH-1:0] ds, d_o, d_a, d_i, d_f, dc;
      ds  = fm(fm(dh, o), ONE - fm(t, t)) + dcn;
      d_o = fm(fm(dh, t), fm(o, ONE - o));
      d_a = fm(fm(ds, i), ONE - fm(a, a));
      d_i = fm(fm(ds, a), fm(i, ONE - i));
      d_f = fm(fm(ds, cp), fm(f, ONE - f));
      dc  = fm(ds, f);
      return {d_a, d_i, d_f, d_o, ds, dc};
   endfunction

   // driver tasks
   task automatic set_inputs(input logic [WIDTH-1:0] a, i, f, o, c, cp, dh, dcn);
      i_a = a; i_i = i; i_f = f; i_o = o;
      i_c = c; i_c_prev = cp; i_dh = dh; i_dc_next = dcn;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
   endtask

   // returns the cycle (relative to the capture cycle) in which o_done is seen, 0 on timeout
   task automatic wait_done(output int l);
      l = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (o_done === 1'b1) begin
            l = k;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
      total++; if (res !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", res); end
      rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_directed(input string name, input logic [WIDTH-1:0] dh, input logic [WIDTH-1:0] dcn,
                                input logic [RW-1:0] expv);
      set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, dh, dcn);
      exp_q.push_back(expv);
      pulse_start();
      wait_done(lat);
      total++; if (lat !== 17) begin bad++; $display("FAIL %s_latency got=%0d want=17", name, lat); end
      exp_v = exp_q.pop_front();
      total++; if (res !== exp_v) begin bad++; $display("FAIL %s_result got=%h want=%h", name, res, exp_v); end
      @(negedge clk);
      total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         bad++; $display("FAIL %s_after got done=%b busy=%b want 0 0", name, o_done, o_busy);
      end
   endtask

   task automatic test_ignore_start();
      set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, ONE, 32'h0);
      exp_q.push_back(EXP_T1);
      pulse_start();
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         total++; if (o_busy !== (k <= 17)) begin bad++; $display("FAIL ign_busy cyc=%0d got=%b want=%b", k, o_busy, k <= 17); end
         total++; if (o_done !== (k == 17)) begin bad++; $display("FAIL ign_done cyc=%0d got=%b want=%b", k, o_done, k == 17); end
         if (k == 17) begin
            exp_v = exp_q.pop_front();
            total++; if (res !== exp_v) begin bad++; $display("FAIL ign_result got=%h want=%h", res, exp_v); end
         end
         @(posedge clk); #1;
         i_start = ((k + 1) == 5) || ((k + 1) == 17);
         if ((k + 1) == 5)  set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, 32'h0, ONE);
         if ((k + 1) == 17) set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, 32'hFF000000, 32'h0);
      end
      i_start = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, 32'h0, ONE);
      pulse_start();
      repeat (7) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", o_busy); end
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=%b want=0", o_done); end
      total++; if (res !== '0) begin bad++; $display("FAIL mid_reset_outputs got=%h want=0", res); end
      repeat (2) @(posedge clk);
      set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, ONE, 32'h0);
      i_start = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      #1 i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL release_start_ignored got busy=%b want=0", o_busy); end
      end
      test_directed("post_reset", ONE, 32'h0, EXP_T1);
   endtask

   task automatic test_back_to_back();
      int ndone;
      ndone = 0;
      set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, 32'h0, ONE);
      repeat (3) exp_q.push_back(EXP_T2);
      @(posedge clk); #1 i_start = 1'b1;
      for (int k = 1; k <= 53; k++) begin
         @(posedge clk); #1;
         if ((k % 18) >= 1 && (k % 18) <= 16)
            set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         else
            set_inputs(32'h0, HALF, HALF, HALF, 32'h0, 32'h0, 32'h0, ONE);
         if (k == 53) i_start = 1'b0;
         @(negedge clk);
         total++; if (o_done !== ((k % 18) == 17)) begin
            bad++; $display("FAIL b2b_done cyc=%0d got=%b want=%b", k, o_done, (k % 18) == 17);
         end
         if (o_done === 1'b1 && exp_q.size() > 0) begin
            ndone++;
            exp_v = exp_q.pop_front();
            total++; if (res !== exp_v) begin bad++; $display("FAIL b2b_result n=%0d got=%h want=%h", ndone, res, exp_v); end
         end
      end
      total++; if (ndone !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", ndone); end
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want=0", o_busy); end
   endtask

   // c = +/-1.0 exercises the tanh path: the piecewise-linear block gives 0.375 + 1.0/4 = 0.625
   task automatic test_tanh_path();
      logic [WIDTH-1:0] cs [2];
      logic [WIDTH-1:0] ts [2];
      cs[0] = ONE;          ts[0] = 32'h00A00000;
      cs[1] = 32'hFF000000; ts[1] = 32'hFF600000;
      for (int n = 0; n < 2; n++) begin
         set_inputs(32'h00400000, HALF, 32'h00C00000, HALF, cs[n], HALF, ONE, 32'h00200000);
         exp_q.push_back(model(32'h00400000, HALF, 32'h00C00000, HALF, ts[n], HALF, ONE, 32'h00200000));
         pulse_start();
         wait_done(lat);
         total++; if (lat !== 17) begin bad++; $display("FAIL tanh_latency n=%0d got=%0d want=17", n, lat); end
         exp_v = exp_q.pop_front();
         total++; if (res !== exp_v) begin bad++; $display("FAIL tanh_result n=%0d got=%h want=%h", n, res, exp_v); end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, i, f, o, cp, dh, dcn;
      for (int n = 0; n < 8; n++) begin
         a   = 32'($urandom_range(0, 32'h01000000));
         i   = 32'($urandom_range(0, 32'h01000000));
         f   = 32'($urandom_range(0, 32'h01000000));
         o   = 32'($urandom_range(0, 32'h01000000));
         cp  = 32'($urandom_range(0, 32'h04000000)) - 32'h02000000;
         dh  = 32'($urandom_range(0, 32'h04000000)) - 32'h02000000;
         dcn = 32'($urandom_range(0, 32'h02000000)) - 32'h01000000;
         set_inputs(a, i, f, o, 32'h0, cp, dh, dcn);
         exp_q.push_back(model(a, i, f, o, 32'h0, cp, dh, dcn));
         pulse_start();
         wait_done(lat);
         total++; if (lat !== 17) begin bad++; $display("FAIL rand_latency n=%0d got=%0d want=17", n, lat); end
         exp_v = exp_q.pop_front();
         total++; if (res !== exp_v) begin bad++; $display("FAIL rand_result n=%0d got=%h want=%h", n, res, exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_directed("basic", ONE, 32'h0, EXP_T1);
      test_directed("dc_next", 32'h0, ONE, EXP_T2);
      test_directed("neg_dh", 32'hFF000000, 32'h0, EXP_T3);
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_tanh_path();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
